// File: rtl/exp5_apresenta_sequencia.sv
// Sequence presenter: steps endereco from 0 to limite, lighting leds with
// each memory element for T_ON cycles followed by a T_OFF blank gap.
package exp5_pkg;
  typedef enum logic [3:0] {
    INICIAL    = 4'd0,
    PREPARACAO = 4'd1,
    CARREGA    = 4'd2,
    MOSTRA     = 4'd3,
    INTERVALO  = 4'd4,
    PROXIMO    = 4'd5,
    FIM        = 4'd6
  } estado_t;
endpackage

module exp5_apresenta_sequencia
  import exp5_pkg::*;
#(
  parameter int T_ON  = 4,
  parameter int T_OFF = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] limite,
  input  logic [3:0] dado_mem,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       exibindo,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam logic [7:0] ON_LAST  = 8'(T_ON - 1);
  localparam logic [7:0] OFF_LAST = 8'(T_OFF - 1);

  estado_t    estado;
  logic [7:0] timer;
  logic [3:0] dado;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= INICIAL;
      timer    <= 8'd0;
      dado     <= 4'd0;
      endereco <= 4'd0;
    end else begin
      case (estado)
        INICIAL: begin
          if (iniciar) estado <= PREPARACAO;
        end
        PREPARACAO: begin
          endereco <= 4'd0;
          timer    <= 8'd0;
          estado   <= CARREGA;
        end
        CARREGA: begin
          dado   <= dado_mem;
          timer  <= 8'd0;
          estado <= MOSTRA;
        end
        MOSTRA: begin
          if (timer == ON_LAST) begin
            timer  <= 8'd0;
            estado <= INTERVALO;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        INTERVALO: begin
          if (timer == OFF_LAST) begin
            timer  <= 8'd0;
            estado <= (endereco == limite) ? FIM : PROXIMO;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        PROXIMO: begin
          endereco <= endereco + 4'd1;
          estado   <= CARREGA;
        end
        FIM: begin
          estado <= INICIAL;
        end
        // corrupted state register recovers through inicial
        default: begin
          estado <= INICIAL;
        end
      endcase
    end
  end

  always_comb begin
    leds      = 4'd0;
    exibindo  = 1'b0;
    pronto    = 1'b0;
    db_estado = 4'hF;
    case (estado)
      INICIAL: begin
        db_estado = 4'd0;
      end
      PREPARACAO: begin
        db_estado = 4'd1;
        exibindo  = 1'b1;
      end
      CARREGA: begin
        db_estado = 4'd2;
        exibindo  = 1'b1;
      end
      MOSTRA: begin
        db_estado = 4'd3;
        exibindo  = 1'b1;
        leds      = dado;
      end
      INTERVALO: begin
        db_estado = 4'd4;
        exibindo  = 1'b1;
      end
      PROXIMO: begin
        db_estado = 4'd5;
        exibindo  = 1'b1;
      end
      FIM: begin
        db_estado = 4'd6;
        pronto    = 1'b1;
      end
      default: begin
        db_estado = 4'hF;
      end
    endcase
  end

endmodule

// File: tb/tb_exp5_apresenta_sequencia.sv
// Bench: two presenters (default and 1/1 timing) against a timeline model
// built from the presentation rules, plus directed literal checks.
module tb_exp5_apresenta_sequencia;

  typedef struct packed {
    logic [3:0] db;
    logic [3:0] leds;
    logic [3:0] addr;
    logic       ex;
    logic       pr;
  } ent_t;

  localparam int TON0  = 4;
  localparam int TOFF0 = 2;
  localparam int TON1  = 1;
  localparam int TOFF1 = 1;

  logic       clock;
  logic       reset    [2];
  logic       iniciar  [2];
  logic [3:0] limite   [2];
  logic [3:0] dado_mem [2];
  logic [3:0] endereco [2];
  logic [3:0] leds     [2];
  logic       exibindo [2];
  logic       pronto   [2];
  logic [3:0] db_estado[2];

  logic [3:0] mem[2][16];
  ent_t       tl[2][256];
  int         len[2];
  int         pos[2];
  ent_t       cur[2];
  int         checks;
  int         errors;
  bit         go;

  exp5_apresenta_sequencia #(.T_ON(TON0), .T_OFF(TOFF0)) dut0 (
    .clock(clock), .reset(reset[0]), .iniciar(iniciar[0]),
    .limite(limite[0]), .dado_mem(dado_mem[0]),
    .endereco(endereco[0]), .leds(leds[0]), .exibindo(exibindo[0]),
    .pronto(pronto[0]), .db_estado(db_estado[0])
  );

  exp5_apresenta_sequencia #(.T_ON(TON1), .T_OFF(TOFF1)) dut1 (
    .clock(clock), .reset(reset[1]), .iniciar(iniciar[1]),
    .limite(limite[1]), .dado_mem(dado_mem[1]),
    .endereco(endereco[1]), .leds(leds[1]), .exibindo(exibindo[1]),
    .pronto(pronto[1]), .db_estado(db_estado[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    dado_mem[0] = mem[0][endereco[0]];
    dado_mem[1] = mem[1][endereco[1]];
  end

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic ent_t mk(int db, int l, int a, bit ex, bit pr);
    ent_t e;
    e.db   = 4'(db);
    e.leds = 4'(l);
    e.addr = 4'(a);
    e.ex   = ex;
    e.pr   = pr;
    return e;
  endfunction

  // whole presentation as a list of per-cycle expected outputs
  task automatic build(input int g);
    int n;
    int L;
    int ton;
    int toff;
    ton  = (g == 0) ? TON0 : TON1;
    toff = (g == 0) ? TOFF0 : TOFF1;
    L    = int'(limite[g]);
    n    = 0;
    tl[g][n++] = mk(1, 0, int'(cur[g].addr), 1, 0);
    for (int i = 0; i <= L; i++) begin
      tl[g][n++] = mk(2, 0, i, 1, 0);
      for (int t = 0; t < ton; t++) tl[g][n++] = mk(3, int'(mem[g][i]), i, 1, 0);
      for (int t = 0; t < toff; t++) tl[g][n++] = mk(4, 0, i, 1, 0);
      if (i < L) tl[g][n++] = mk(5, 0, i, 1, 0);
    end
    tl[g][n++] = mk(6, 0, L, 0, 1);
    len[g] = n;
  endtask

  initial begin
    cur[0] = '0;
    cur[1] = '0;
    len    = '{0, 0};
    pos    = '{0, 0};
    forever begin
      @(posedge clock);
      for (int g = 0; g < 2; g++) begin
        if (reset[g]) begin
          len[g] = 0;
          pos[g] = 0;
          cur[g] = '0;
        end else if (pos[g] < len[g]) begin
          cur[g] = tl[g][pos[g]];
          pos[g]++;
        end else if (cur[g].db == 4'd0 && iniciar[g]) begin
          build(g);
          cur[g] = tl[g][0];
          pos[g] = 1;
        end else begin
          cur[g] = mk(0, 0, int'(cur[g].addr), 0, 0);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (go) begin
        for (int g = 0; g < 2; g++) begin
          chk($sformatf("d%0d_db", g), 8'(db_estado[g]), 8'(cur[g].db));
          chk($sformatf("d%0d_leds", g), 8'(leds[g]), 8'(cur[g].leds));
          chk($sformatf("d%0d_addr", g), 8'(endereco[g]), 8'(cur[g].addr));
          chk($sformatf("d%0d_ex", g), 8'(exibindo[g]), 8'(cur[g].ex));
          chk($sformatf("d%0d_pr", g), 8'(pronto[g]), 8'(cur[g].pr));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  initial begin
    bit found;
    bit saw;
    checks  = 0;
    errors  = 0;
    go      = 1'b0;
    reset   = '{1'b1, 1'b1};
    iniciar = '{1'b0, 1'b0};
    limite  = '{4'd0, 4'd0};
    for (int i = 0; i < 16; i++) begin
      mem[0][i] = 4'd0;
      mem[1][i] = 4'd0;
    end
    tick(2);
    go = 1'b1;
    chk("reset_db", 8'(db_estado[0]), 8'h0);
    chk("reset_addr", 8'(endereco[0]), 8'h0);
    reset = '{1'b0, 1'b0};
    tick(1);

    // single element, value 5
    mem[0][0] = 4'd5;
    limite[0] = 4'd0;
    iniciar[0] = 1'b1;
    tick(1);
    iniciar[0] = 1'b0;
    chk("l0_prep_c1", 8'(db_estado[0]), 8'h1);
    tick(2);
    chk("l0_leds_c3", 8'(leds[0]), 8'h5);
    tick(3);
    chk("l0_leds_c6", 8'(leds[0]), 8'h5);
    tick(1);
    chk("l0_blank_c7", 8'(leds[0]), 8'h0);
    tick(2);
    chk("l0_pronto_c9", 8'(pronto[0]), 8'h1);
    tick(1);
    chk("l0_pronto_c10", 8'(pronto[0]), 8'h0);
    tick(2);

    // three elements 3, A, 0
    mem[0][0] = 4'h3;
    mem[0][1] = 4'hA;
    mem[0][2] = 4'h0;
    limite[0] = 4'd2;
    iniciar[0] = 1'b1;
    tick(1);
    iniciar[0] = 1'b0;
    tick(2);
    chk("l2_leds_c3", 8'(leds[0]), 8'h3);
    tick(8);
    chk("l2_leds_c11", 8'(leds[0]), 8'hA);
    chk("l2_addr_c11", 8'(endereco[0]), 8'h1);
    tick(8);
    chk("l2_db_c19", 8'(db_estado[0]), 8'h3);
    chk("l2_addr_c19", 8'(endereco[0]), 8'h2);
    tick(6);
    chk("l2_pronto_c25", 8'(pronto[0]), 8'h1);
    tick(2);

    // iniciar held high restarts right after fim
    mem[0][0] = 4'd5;
    limite[0] = 4'd0;
    iniciar[0] = 1'b1;
    tick(9);
    chk("hold_pronto_c9", 8'(pronto[0]), 8'h1);
    tick(1);
    chk("hold_inicial_c10", 8'(db_estado[0]), 8'h0);
    tick(1);
    chk("hold_prep_c11", 8'(db_estado[0]), 8'h1);
    for (int k = 0; k < 10; k++) begin
      iniciar[0] = 1'($urandom_range(0, 1));
      tick(1);
    end
    iniciar[0] = 1'b0;
    tick(20);

    // reset during element 1 display
    mem[0][0] = 4'h3;
    mem[0][1] = 4'hA;
    mem[0][2] = 4'h0;
    limite[0] = 4'd2;
    iniciar[0] = 1'b1;
    tick(1);
    iniciar[0] = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (db_estado[0] == 4'd3 && endereco[0] == 4'd1) found = 1'b1;
      else tick(1);
    end
    chk("reach_mostra1", 8'(found), 8'h1);
    reset[0] = 1'b1;
    tick(1);
    reset[0] = 1'b0;
    chk("abort_db", 8'(db_estado[0]), 8'h0);
    chk("abort_leds", 8'(leds[0]), 8'h0);
    chk("abort_addr", 8'(endereco[0]), 8'h0);
    chk("abort_ex", 8'(exibindo[0]), 8'h0);
    saw = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (pronto[0]) saw = 1'b1;
      tick(1);
    end
    chk("abort_no_pronto", 8'(saw), 8'h0);

    // fastest timing, full 16-element sequence
    for (int i = 0; i < 16; i++) mem[1][i] = 4'(i);
    limite[1] = 4'hF;
    iniciar[1] = 1'b1;
    tick(1);
    iniciar[1] = 1'b0;
    tick(2);
    chk("l15_leds_c3", 8'(leds[1]), 8'h0);
    tick(4);
    chk("l15_leds_c7", 8'(leds[1]), 8'h1);
    tick(57);
    chk("l15_db_c64", 8'(db_estado[1]), 8'h4);
    chk("l15_addr_c64", 8'(endereco[1]), 8'hF);
    tick(1);
    chk("l15_pronto_c65", 8'(pronto[1]), 8'h1);
    chk("l15_addr_c65", 8'(endereco[1]), 8'hF);
    tick(3);

    // corrupted state register
    force dut0.estado = exp5_pkg::estado_t'(4'hA);
    cur[0] = mk(15, 0, int'(cur[0].addr), 0, 0);
    #1;
    chk("illegal_db", 8'(db_estado[0]), 8'hF);
    #6;
    release dut0.estado;
    tick(1);
    chk("illegal_recover", 8'(db_estado[0]), 8'h0);
    tick(1);

    // randomized traffic on both instances
    for (int k = 0; k < 1500; k++) begin
      for (int g = 0; g < 2; g++) begin
        if (cur[g].db == 4'd0 && pos[g] >= len[g] && $urandom_range(0, 3) == 0) begin
          limite[g] = 4'($urandom_range(0, 15));
          for (int i = 0; i < 16; i++) mem[g][i] = 4'($urandom_range(0, 15));
        end
        iniciar[g] = ($urandom_range(0, 7) == 0);
        reset[g]   = ($urandom_range(0, 199) == 0);
      end
      tick(1);
    end
    iniciar = '{1'b0, 1'b0};
    reset   = '{1'b0, 1'b0};
    tick(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
